// File: rtl/note_pkg.sv
// Shared constants for the polyphonic note generator:
// mode codes, envelope states, volume table and LFSR taps.
package note_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_NOISE  = 2'd2;

  localparam logic [1:0] ENV_IDLE    = 2'd0;
  localparam logic [1:0] ENV_ATTACK  = 2'd1;
  localparam logic [1:0] ENV_SUSTAIN = 2'd2;
  localparam logic [1:0] ENV_RELEASE = 2'd3;

  localparam logic [9:0]  DUTY_MAX  = 10'd1000;
  localparam logic [7:0]  ENV_MAX   = 8'd255;
  // Galois right-shift mask for x^16+x^14+x^13+x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] vol_lut(input logic [2:0] v);
    logic [15:0] r;
    case (v)
      3'd0:    r = 16'h0000;
      3'd1:    r = 16'h1000;
      3'd2:    r = 16'h2000;
      3'd3:    r = 16'h3000;
      3'd4:    r = 16'h4000;
      default: r = 16'h5000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/poly_note_gen_voice.sv
// One voice: config regs, tone phase, noise LFSR,
// gated linear envelope and the registered sample.
module voice_channel
  import note_pkg::*;
#(
  parameter int          DIV_W     = 22,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [9:0]         cfg_duty,
  input  logic [1:0]         cfg_mode,
  input  logic [1:0]         cfg_pan,
  input  logic               gate,
  input  logic               env_tick,
  input  logic [2:0]         volume,
  output logic signed [15:0] sample,
  output logic [1:0]         pan,
  output logic               busy
);

  logic [DIV_W-1:0] div;
  logic [9:0]       duty;
  logic [1:0]       mode;
  logic [DIV_W-1:0] thr;
  logic [DIV_W-1:0] phase;
  logic [15:0]      lfsr;
  logic [7:0]       env;
  logic [1:0]       state;

  logic [DIV_W+9:0] prod;
  logic [DIV_W-1:0] thr_next;
  logic [23:0]      env_prod;
  logic [15:0]      amp;
  logic             wrap;
  logic             silent;
  logic             wave_hi;

  assign prod     = {10'd0, div} * {{DIV_W{1'b0}}, duty};
  assign thr_next = DIV_W'(prod / {{DIV_W{1'b0}}, DUTY_MAX});
  assign env_prod = {16'd0, env} * {8'd0, vol_lut(volume)};
  assign amp      = 16'(env_prod >> 8);
  assign wrap     = (div > DIV_W'(1)) &&
                    (phase >= div - DIV_W'(1));
  assign silent   = !(mode == MODE_SQUARE || mode == MODE_NOISE) ||
                    (div <= DIV_W'(1));
  assign wave_hi  = (mode == MODE_NOISE) ? lfsr[0] : (phase < thr);
  assign busy     = (state != ENV_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= DIV_W'(1);
      duty  <= 10'd125;
      mode  <= MODE_OFF;
      pan   <= 2'b11;
      thr   <= '0;
      phase <= '0;
      lfsr  <= LFSR_SEED;
    end else begin
      thr <= thr_next;
      if (wr) begin
        div   <= cfg_div;
        duty  <= (cfg_duty > DUTY_MAX) ? DUTY_MAX : cfg_duty;
        mode  <= cfg_mode;
        pan   <= cfg_pan;
        phase <= '0;
      end else if (wrap) begin
        phase <= '0;
        lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
      end else if (div > DIV_W'(1)) begin
        phase <= phase + DIV_W'(1);
      end else begin
        phase <= '0;
      end
    end
  end

  // Gate changes act on the next edge; only the level steps wait for a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENV_IDLE;
      env   <= '0;
    end else begin
      unique case (state)
        ENV_IDLE: begin
          if (gate) state <= ENV_ATTACK;
        end
        ENV_ATTACK: begin
          if (!gate) begin
            state <= ENV_RELEASE;
          end else if (env == ENV_MAX) begin
            state <= ENV_SUSTAIN;
          end else if (env_tick) begin
            env <= env + 8'd1;
            if (env == ENV_MAX - 8'd1) state <= ENV_SUSTAIN;
          end
        end
        ENV_SUSTAIN: begin
          if (!gate) state <= ENV_RELEASE;
        end
        ENV_RELEASE: begin
          if (gate) begin
            state <= ENV_ATTACK;
          end else if (env == 8'd0) begin
            state <= ENV_IDLE;
          end else if (env_tick) begin
            env <= env - 8'd1;
            if (env == 8'd1) state <= ENV_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sample <= '0;
    else if (silent)  sample <= '0;
    else if (wave_hi) sample <= $signed(amp);
    else              sample <= -$signed(amp);
  end

endmodule

// File: rtl/poly_note_gen.sv
// Multi-voice square/noise generator: config decode,
// shared envelope prescaler and saturating stereo mixer.
module poly_note_gen
  import note_pkg::*;
#(
  parameter int          NUM_VOICES   = 2,
  parameter int          DIV_W        = 22,
  parameter int          ENV_STEP_DIV = 100000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [VW-1:0]         cfg_voice,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [9:0]            cfg_duty,
  input  logic [1:0]            cfg_mode,
  input  logic [1:0]            cfg_pan,
  input  logic [NUM_VOICES-1:0] gate,
  input  logic [2:0]            volume,
  output logic signed [15:0]    audio_left,
  output logic signed [15:0]    audio_right,
  output logic [NUM_VOICES-1:0] busy
);

  localparam int PW = (ENV_STEP_DIV > 2) ? $clog2(ENV_STEP_DIV) : 1;
  localparam int AW = 16 + $clog2(NUM_VOICES) + 1;

  logic [PW-1:0]         pcnt;
  logic                  env_tick;
  logic [NUM_VOICES-1:0] wr;
  logic signed [15:0]    samples [NUM_VOICES];
  logic [1:0]            pans    [NUM_VOICES];
  logic signed [AW-1:0]  sum_l;
  logic signed [AW-1:0]  sum_r;

  assign env_tick = (pcnt == PW'(ENV_STEP_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pcnt <= '0;
    else if (env_tick) pcnt <= '0;
    else               pcnt <= pcnt + PW'(1);
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    assign wr[i] = cfg_valid && (cfg_voice == VW'(i));

    voice_channel #(
      .DIV_W     (DIV_W),
      .LFSR_SEED (LFSR_SEED)
    ) u_voice (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr[i]),
      .cfg_div  (cfg_div),
      .cfg_duty (cfg_duty),
      .cfg_mode (cfg_mode),
      .cfg_pan  (cfg_pan),
      .gate     (gate[i]),
      .env_tick (env_tick),
      .volume   (volume),
      .sample   (samples[i]),
      .pan      (pans[i]),
      .busy     (busy[i])
    );
  end

  function automatic logic [15:0] sat(input logic signed [AW-1:0] x);
    if (x > AW'(32767))       return 16'h7FFF;
    else if (x < AW'(-32768)) return 16'h8000;
    else                      return x[15:0];
  endfunction

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (pans[i][1]) sum_l = sum_l + AW'(samples[i]);
      if (pans[i][0]) sum_r = sum_r + AW'(samples[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_left  <= '0;
      audio_right <= '0;
    end else begin
      audio_left  <= sat(sum_l);
      audio_right <= sat(sum_r);
    end
  end

endmodule

// File: tb/tb_poly_note_gen.sv
// Randomised bench for poly_note_gen against a cycle model
// built from the behavioural rules, plus literal checkpoints.
module tb_poly_note_gen;

  localparam int NV   = 3;
  localparam int DW   = 12;
  localparam int ESD  = 2;
  localparam int SEED = 'hACE1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic [1:0]     cfg_voice = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic [9:0]     cfg_duty = '0;
  logic [1:0]     cfg_mode = '0;
  logic [1:0]     cfg_pan = '0;
  logic [NV-1:0]  gate = '0;
  logic [2:0]     volume = '0;
  logic [15:0]    audio_left;
  logic [15:0]    audio_right;
  logic [NV-1:0]  busy;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 0;

  poly_note_gen #(
    .NUM_VOICES   (NV),
    .DIV_W        (DW),
    .ENV_STEP_DIV (ESD),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_voice   (cfg_voice),
    .cfg_div     (cfg_div),
    .cfg_duty    (cfg_duty),
    .cfg_mode    (cfg_mode),
    .cfg_pan     (cfg_pan),
    .gate        (gate),
    .volume      (volume),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_div[NV], m_duty[NV], m_mode[NV], m_pan[NV], m_thr[NV];
  int m_phase[NV], m_lfsr[NV], m_env[NV], m_smp[NV];
  int m_rising[NV];
  bit m_active[NV];
  int m_pcnt, m_left, m_right;
  int lut[8] = '{0, 'h1000, 'h2000, 'h3000, 'h4000, 'h5000, 'h5000, 'h5000};

  function automatic int clamp16(input int s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic int model_busy();
    int b = 0;
    for (int v = 0; v < NV; v++) if (m_active[v]) b |= (1 << v);
    return b;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_div[v] = 1; m_duty[v] = 125; m_mode[v] = 0; m_pan[v] = 3;
      m_thr[v] = 0; m_phase[v] = 0; m_lfsr[v] = SEED; m_env[v] = 0;
      m_smp[v] = 0; m_active[v] = 0; m_rising[v] = 0;
    end
    m_pcnt = 0; m_left = 0; m_right = 0;
  endtask

  task automatic model_step();
    bit tick;
    int l = 0, r = 0;
    tick = (m_pcnt == ESD - 1);
    m_pcnt = tick ? 0 : m_pcnt + 1;
    for (int v = 0; v < NV; v++) begin
      if (m_pan[v][1]) l += m_smp[v];
      if (m_pan[v][0]) r += m_smp[v];
    end
    m_left = clamp16(l);
    m_right = clamp16(r);
    for (int v = 0; v < NV; v++) begin
      bit audible, hi;
      int a;
      audible = (m_mode[v] == 1 || m_mode[v] == 2) && m_div[v] > 1;
      hi = (m_mode[v] == 2) ? m_lfsr[v][0] : (m_phase[v] < m_thr[v]);
      a = (m_env[v] * lut[volume]) / 256;
      m_smp[v] = !audible ? 0 : (hi ? a : -a);
      m_thr[v] = (m_div[v] * m_duty[v]) / 1000;
      if (cfg_valid && int'(cfg_voice) == v) begin
        m_div[v] = cfg_div;
        m_duty[v] = (cfg_duty > 1000) ? 1000 : cfg_duty;
        m_mode[v] = cfg_mode;
        m_pan[v] = cfg_pan;
        m_phase[v] = 0;
      end else if (m_div[v] > 1 && m_phase[v] + 1 >= m_div[v]) begin
        m_phase[v] = 0;
        if (m_lfsr[v] % 2 == 1) m_lfsr[v] = (m_lfsr[v] / 2) ^ 'hB400;
        else                    m_lfsr[v] = m_lfsr[v] / 2;
      end else if (m_div[v] > 1) begin
        m_phase[v]++;
      end
      // envelope: activity + direction, level moves on ticks
      if (gate[v]) begin
        if (!m_active[v] || !m_rising[v]) begin
          m_active[v] = 1; m_rising[v] = 1;
        end else if (tick && m_env[v] < 255) begin
          m_env[v]++;
        end
      end else if (m_active[v]) begin
        if (m_rising[v]) m_rising[v] = 0;
        else if (m_env[v] == 0) m_active[v] = 0;
        else if (tick) begin
          m_env[v]--;
          if (m_env[v] == 0) m_active[v] = 0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("left",  int'($signed(audio_left)),  m_left);
        chk("right", int'($signed(audio_right)), m_right);
        chk("busy",  int'(busy), model_busy());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_cfg(input int v, input int d, input int du,
                        input int mo, input int pn);
    cfg_valid = 1'b1;
    cfg_voice = 2'(v);
    cfg_div   = DW'(d);
    cfg_duty  = 10'(du);
    cfg_mode  = 2'(mo);
    cfg_pan   = 2'(pn);
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int pos, neg;
    checking = 1;
    cyc(3);
    chk("rst_left", int'(audio_left), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    cyc(20);
    chk("idle_left", int'(audio_left), 0);
    chk("idle_right", int'(audio_right), 0);
    chk("idle_busy", int'(busy), 0);

    // voice0 square 10/500, left only, full envelope
    volume = 3'd5;
    wr_cfg(0, 10, 500, 1, 2);
    gate = 3'b001;
    cyc(600);
    pos = 0; neg = 0;
    for (int i = 0; i < 10; i++) begin
      if (audio_left == 16'h4FB0) pos++;
      if (audio_left == 16'hB050) neg++;
      chk("sq_right", int'(audio_right), 0);
      cyc(1);
    end
    chk("sq_hi_count", pos, 5);
    chk("sq_lo_count", neg, 5);

    // duty clamp to full-high, then duty 0
    wr_cfg(0, 8, 1023, 1, 2);
    cyc(4);
    for (int i = 0; i < 12; i++) begin
      chk("clamp_hi", int'(audio_left), 'h4FB0);
      cyc(1);
    end
    wr_cfg(0, 8, 0, 1, 2);
    cyc(4);
    chk("duty0_lo", int'(audio_left), 'hB050);

    // release to ~200, then retrigger
    gate = 3'b000;
    for (int i = 0; i < 110; i++) begin
      chk("rel_busy", int'(busy[0]), 1);
      cyc(1);
    end
    gate = 3'b001;
    for (int i = 0; i < 130; i++) begin
      chk("retrig_busy", int'(busy[0]), 1);
      cyc(1);
    end
    chk("retrig_full", int'(audio_left), 'hB050);

    // random traffic, including writes to the absent voice 3
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)
        wr_cfg($urandom_range(3), $urandom_range(40),
               $urandom_range(1023), $urandom_range(3),
               $urandom_range(3));
      else
        cyc(1);
      if ($urandom_range(39) == 0) gate[$urandom_range(NV-1)] ^= 1'b1;
      if ($urandom_range(99) == 0) volume = 3'($urandom_range(7));
    end

    // saturation both polarities
    volume = 3'd5;
    gate = 3'b111;
    for (int v = 0; v < NV; v++) wr_cfg(v, 4, 1000, 1, 3);
    cyc(600);
    chk("sat_pos_l", int'(audio_left), 'h7FFF);
    chk("sat_pos_r", int'(audio_right), 'h7FFF);
    for (int v = 0; v < NV; v++) wr_cfg(v, 4, 0, 1, 3);
    cyc(4);
    chk("sat_neg_l", int'(audio_left), 'h8000);
    chk("sat_neg_r", int'(audio_right), 'h8000);

    // asynchronous reset mid-note, gate held
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_left", int'(audio_left), 0);
    chk("arst_right", int'(audio_right), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(1);
    chk("post_rst_busy", int'(busy), 7);
    for (int i = 0; i < 20; i++) begin
      chk("post_rst_silent", int'(audio_left), 0);
      cyc(1);
    end

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/poly_note_gen.md
Name: poly_note_gen

Overview:
Parametrised successor to the single-voice square/noise note generator. Provides NUM_VOICES independent voices. Each voice has:
- a runtime-programmable period, duty and mode
- a per-voice gated linear attack/release envelope
- per-voice left/right pan

Voices are summed with saturation into true stereo outputs. The block sits between the keyboard/sequencer control logic and the audio DAC serialiser.

Parameters:
NUM_VOICES, 2, number of independent voices (1..8)
DIV_W, 22, width of period divider (clk cycles per tone period)
ENV_STEP_DIV, 100000, clk cycles per envelope step (>=2)
LFSR_SEED, 16'hACE1, reset seed of every voice's noise LFSR; must be nonzero

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  one-cycle config write strobe
cfg_voice  in  $clog2(NUM_VOICES) (min 1)  target voice of write
cfg_div  in  DIV_W  tone period in clk cycles; 0/1 = silent
cfg_duty  in  10  high-time in per-mille (0..1000)
cfg_mode  in  2  0=off, 1=square, 2=noise, 3=reserved (treated as off)
cfg_pan  in  2  [1]=route to left, [0]=route to right
gate  in  NUM_VOICES  per-voice key-held level
volume  in  3  master volume index 0..7
audio_left  out  16  signed two's-complement left sample
audio_right  out  16  signed two's-complement right sample
busy  out  NUM_VOICES  voice envelope nonzero or in ATTACK

Behaviour:
- Reset (async, rst_n=0): audio_left/right=0, busy=0, and per voice:
  - div=1, duty=125, mode=off, pan=2'b11
  - phase=0, env=0, state=IDLE, lfsr=LFSR_SEED
  - env prescaler=0
- Config write:
  - On a cfg_valid edge, the selected voice latches div/mode/pan. Duty is clamped to 1000.
  - phase resets to 0, even if the values are unchanged.
  - thr = (div*duty_clamped)/1000 is registered one cycle later. During that cycle, the old thr is used.
  - A cfg_voice >= NUM_VOICES is ignored.
  - A write coinciding with a phase wrap: the write wins.
- Phase counter: counts 0..div-1, then wraps to 0. Held at 0 when div<=1.
  - wave_hi = (phase < thr).
  - duty=0 gives constant low; duty=1000 gives constant high.
- Noise LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances once per phase wrap. Noise wave_hi = lfsr[0].
- Envelope prescaler: shared counter 0..ENV_STEP_DIV-1. Emits a one-cycle env_tick at the wrap.
- Envelope FSM per voice (env is 8-bit):
  - IDLE: gate=1 -> ATTACK.
  - ATTACK: env+1 per tick. Reaching 255 -> SUSTAIN.
  - SUSTAIN: hold 255.
  - RELEASE: env-1 per tick. Reaching 0 -> IDLE.
  - gate=0 in ATTACK or SUSTAIN -> RELEASE, keeping the current env.
  - gate=1 in RELEASE -> ATTACK, continuing from the current env (no restart from 0).
  - Gate edges take effect the cycle after sampling, independent of env_tick.
  - env never wraps.
- busy[i] = (state != IDLE).
- Amplitude:
  - VOL_LUT = {0, 0x1000, 0x2000, 0x3000, 0x4000, 0x5000, 0x5000, 0x5000}.
  - amp = (env * VOL_LUT[volume]) >> 8, 16-bit unsigned, max 0x4FB0.
- Voice sample (registered): 0 if mode off/reserved or div<=1; otherwise +amp if wave_hi, else -amp.
- Mixer (registered):
  - left = sum of samples with pan[1]=1; right = sum with pan[0]=1.
  - Accumulate in 16+clog2(NUM_VOICES)+1 bits, then saturate to [-32768, 32767].
- Latency: wave_hi or env change -> audio output = 2 clk (voice register + mixer register).
- Changing volume mid-note takes effect in 2 clk with no phase disturbance.

Decomposition:
- Package note_pkg holds:
  - mode codes (MODE_OFF, MODE_SQUARE, MODE_NOISE)
  - env state encoding (ENV_IDLE, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE)
  - VOL_LUT, DUTY_MAX=1000, ENV_MAX=255, LFSR taps
- Sub-module voice_channel: one per voice, generated.
  - Contains config registers, thr, phase, LFSR, envelope FSM and the sample register.
  - Inputs: env_tick and volume.
- The top level holds the prescaler, the config decode and the saturating mixer.

Test Plan:
- Reset release, no config -> audio_left/right=0 and busy=0 indefinitely.
- Voice0 square: div=10, duty=500, pan=2'b10, volume=5, ENV_STEP_DIV=2, gate0=1 -> after env reaches 255, left alternates +0x4FB0 for 5 clk / -0x4FB0 for 5 clk; right=0.
- Duty clamp: cfg_duty=1023, div=8 -> thr=8, so wave is constant high and output is +amp steadily. Also duty=0 -> constant -amp.
- Envelope retrigger: gate0 1->0 at env=255, back to 1 at env=200 -> env resumes ATTACK from 200 and reaches 255 after 55 ticks; busy0 stays 1 throughout.
- Saturation: NUM_VOICES=8, all square duty=1000, pan=2'b11, volume=5, env=255 -> sum 8*0x4FB0 clamps to 0x7FFF on both channels.
- Mid-note rst_n pulse (async, not clock-aligned) -> outputs go to 0 immediately. Config returns to defaults (div=1, so silent) even with gate held; busy is 0 until the next cycle with gate sampled high.
